// File: rtl/spatz_pkg.sv
// Shared FP register-file types and sizing constants for the Spatz FPR scoreboard.
package spatz_pkg;

  localparam int unsigned NrFPRegs = 32;
  localparam int unsigned FLEN     = 64;

  typedef logic [$clog2(NrFPRegs)-1:0] fpr_addr_t;
  typedef logic [FLEN-1:0]             fpr_data_t;

endpackage

// File: rtl/spatz_fpr_wb_arbiter.sv
// Round-robin single-grant arbiter for the FPR write-back channels.
module spatz_fpr_wb_arbiter #(
  parameter  int unsigned NrPorts = 2,
  localparam int unsigned IW      = (NrPorts > 1) ? $clog2(NrPorts) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NrPorts-1:0] valid_i,
  output logic [NrPorts-1:0] ready_o,
  output logic               gnt_valid_o,
  output logic [IW-1:0]      gnt_idx_o
);

  logic [IW-1:0] r_ptr;
  logic          w_found;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_cand;

  // Scan starting at the pointer; the first valid channel wins.
  always_comb begin
    w_found = 1'b0;
    w_idx   = r_ptr;
    w_cand  = r_ptr;
    for (int k = 0; k < int'(NrPorts); k++) begin
      w_cand = IW'((int'(r_ptr) + k) % int'(NrPorts));
      if (!w_found && valid_i[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  assign gnt_valid_o = w_found && !rst_i;
  assign gnt_idx_o   = w_idx;

  always_comb begin
    ready_o = '0;
    if (gnt_valid_o) ready_o[w_idx] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (gnt_valid_o) begin
      r_ptr <= (w_idx == IW'(NrPorts - 1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule

// File: rtl/spatz_fpr_scoreboard.sv
// FP register file with per-register pending-write counters and issue hazard check.
// Optional macro SPATZ_FPR_FWD_EN: forward the granted write-back to a stalled last-pending source.
module spatz_fpr_scoreboard
  import spatz_pkg::*;
#(
  parameter  int unsigned NrRegs         = NrFPRegs,
  parameter  int unsigned DataWidth      = FLEN,
  parameter  int unsigned NrReadPorts    = 3,
  parameter  int unsigned NrWbPorts      = 2,
  parameter  int unsigned MaxOutstanding = 3,
  localparam int unsigned AW             = $clog2(NrRegs),
  localparam int unsigned CW             = $clog2(MaxOutstanding + 1),
  localparam int unsigned IW             = (NrWbPorts > 1) ? $clog2(NrWbPorts) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   issue_valid_i,
  output logic                                   issue_ready_o,
  input  logic [NrReadPorts-1:0][AW-1:0]         issue_raddr_i,
  input  logic [NrReadPorts-1:0]                 issue_ruse_i,
  output logic [NrReadPorts-1:0][DataWidth-1:0]  issue_rdata_o,
  input  logic [AW-1:0]                          issue_waddr_i,
  input  logic                                   issue_wuse_i,
  input  logic [NrWbPorts-1:0]                   wb_valid_i,
  output logic [NrWbPorts-1:0]                   wb_ready_o,
  input  logic [NrWbPorts-1:0][AW-1:0]           wb_addr_i,
  input  logic [NrWbPorts-1:0][DataWidth-1:0]    wb_data_i,
  output logic [NrRegs-1:0]                      busy_o,
  output logic                                   err_o
);

  logic [CW-1:0]          r_cnt [NrRegs];
  logic [DataWidth-1:0]   r_rf  [NrRegs];
  logic                   r_err;

  logic                   w_gnt_valid;
  logic [IW-1:0]          w_gnt_idx;
  logic [AW-1:0]          w_wb_addr;
  logic [DataWidth-1:0]   w_wb_data;
  logic                   w_stall;
  logic                   w_issue_hs;
  logic [NrReadPorts-1:0] w_fwd;
  logic [NrRegs-1:0]      w_inc;
  logic [NrRegs-1:0]      w_dec;

  spatz_fpr_wb_arbiter #(
    .NrPorts (NrWbPorts)
  ) i_wb_arbiter (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (wb_valid_i),
    .ready_o     (wb_ready_o),
    .gnt_valid_o (w_gnt_valid),
    .gnt_idx_o   (w_gnt_idx)
  );

  assign w_wb_addr = wb_addr_i[w_gnt_idx];
  assign w_wb_data = wb_data_i[w_gnt_idx];

  // RAW on any used source, or destination already at its pending-write limit.
  always_comb begin
    w_stall = 1'b0;
    w_fwd   = '0;
    for (int p = 0; p < int'(NrReadPorts); p++) begin
      if (issue_ruse_i[p] && (r_cnt[issue_raddr_i[p]] != '0)) begin
`ifdef SPATZ_FPR_FWD_EN
        if (w_gnt_valid && (w_wb_addr == issue_raddr_i[p]) &&
            (r_cnt[issue_raddr_i[p]] == CW'(1))) begin
          w_fwd[p] = 1'b1;
        end else begin
          w_stall = 1'b1;
        end
`else
        w_stall = 1'b1;
`endif
      end
    end
    if (issue_wuse_i && (r_cnt[issue_waddr_i] == CW'(MaxOutstanding))) w_stall = 1'b1;
  end

  assign issue_ready_o = !w_stall;
  assign w_issue_hs    = issue_valid_i && issue_ready_o;

  always_comb begin
    issue_rdata_o = '0;
    for (int p = 0; p < int'(NrReadPorts); p++) begin
      issue_rdata_o[p] = w_fwd[p] ? w_wb_data : r_rf[issue_raddr_i[p]];
    end
  end

  // A write-back to an idle register is a protocol error and must not underflow.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int r = 0; r < int'(NrRegs); r++) begin
      w_inc[r] = w_issue_hs && issue_wuse_i && (issue_waddr_i == AW'(r));
      w_dec[r] = w_gnt_valid && (w_wb_addr == AW'(r)) && (r_cnt[r] != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < int'(NrRegs); r++) r_cnt[r] <= '0;
      r_err <= 1'b0;
    end else begin
      for (int r = 0; r < int'(NrRegs); r++) begin
        if (w_inc[r] && !w_dec[r]) begin
          r_cnt[r] <= r_cnt[r] + 1'b1;
        end else if (w_dec[r] && !w_inc[r]) begin
          r_cnt[r] <= r_cnt[r] - 1'b1;
        end
      end
      if (w_gnt_valid && (r_cnt[w_wb_addr] == '0)) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_gnt_valid) r_rf[w_wb_addr] <= w_wb_data;
  end

  always_comb begin
    busy_o = '0;
    for (int r = 0; r < int'(NrRegs); r++) busy_o[r] = (r_cnt[r] != '0);
  end

  assign err_o = r_err;

endmodule

// File: tb/tb_spatz_fpr_scoreboard.sv
// Randomized + directed bench for spatz_fpr_scoreboard against a behavioural model.
module tb_spatz_fpr_scoreboard;

  localparam int NR   = 32;
  localparam int DW   = 64;
  localparam int NRP  = 3;
  localparam int NWB  = 2;
  localparam int MAXO = 3;
`ifdef SPATZ_FPR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst_i;
  logic                     issue_valid_i;
  logic                     issue_ready_o;
  logic [NRP-1:0][4:0]      issue_raddr_i;
  logic [NRP-1:0]           issue_ruse_i;
  logic [NRP-1:0][DW-1:0]   issue_rdata_o;
  logic [4:0]               issue_waddr_i;
  logic                     issue_wuse_i;
  logic [NWB-1:0]           wb_valid_i;
  logic [NWB-1:0]           wb_ready_o;
  logic [NWB-1:0][4:0]      wb_addr_i;
  logic [NWB-1:0][DW-1:0]   wb_data_i;
  logic [NR-1:0]            busy_o;
  logic                     err_o;

  spatz_fpr_scoreboard dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .issue_valid_i (issue_valid_i),
    .issue_ready_o (issue_ready_o),
    .issue_raddr_i (issue_raddr_i),
    .issue_ruse_i  (issue_ruse_i),
    .issue_rdata_o (issue_rdata_o),
    .issue_waddr_i (issue_waddr_i),
    .issue_wuse_i  (issue_wuse_i),
    .wb_valid_i    (wb_valid_i),
    .wb_ready_o    (wb_ready_o),
    .wb_addr_i     (wb_addr_i),
    .wb_data_i     (wb_data_i),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: pending-write counts, known register values, sticky error, rr pointer.
  int          cnt_m [NR];
  logic [63:0] rf_m  [NR];
  bit          known [NR];
  bit          err_m;
  int          ptr_m;

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    for (int k = 0; k < NWB; k++) begin
      int j;
      j = (ptr_m + k) % NWB;
      if (wb_valid_i[j]) return j;
    end
    return -1;
  endfunction

  function automatic bit can_fwd(int p, int g);
    return FWD && (g >= 0) && (int'(wb_addr_i[g]) == int'(issue_raddr_i[p])) &&
           (cnt_m[issue_raddr_i[p]] == 1);
  endfunction

  function automatic bit model_ready(int g);
    bit rdy;
    rdy = 1'b1;
    for (int p = 0; p < NRP; p++)
      if (issue_ruse_i[p] && cnt_m[issue_raddr_i[p]] > 0 && !can_fwd(p, g)) rdy = 1'b0;
    if (issue_wuse_i && cnt_m[issue_waddr_i] >= MAXO) rdy = 1'b0;
    return rdy;
  endfunction

  task automatic idle();
    issue_valid_i = 1'b0;
    issue_ruse_i  = '0;
    issue_raddr_i = '0;
    issue_wuse_i  = 1'b0;
    issue_waddr_i = '0;
    wb_valid_i    = '0;
    wb_addr_i     = '0;
    wb_data_i     = '0;
  endtask

  task automatic iss(bit wuse, int wa, bit ruse, int ra);
    issue_valid_i    = 1'b1;
    issue_wuse_i     = wuse;
    issue_waddr_i    = 5'(wa);
    issue_ruse_i[0]  = ruse;
    issue_raddr_i[0] = 5'(ra);
  endtask

  task automatic wbs(int ch, int a, logic [63:0] d);
    wb_valid_i[ch] = 1'b1;
    wb_addr_i[ch]  = 5'(a);
    wb_data_i[ch]  = d;
  endtask

  // Called at negedge with inputs driven; checks, clocks once, updates model, returns at negedge.
  task automatic step();
    int g, ia, da, wa;
    bit rdy;
    logic [63:0] d, exp_wr, exp_busy;
    #1;
    g   = model_grant();
    rdy = model_ready(g);
    chk("issue_ready", 64'(issue_ready_o), 64'(rdy));
    exp_wr = '0;
    if (g >= 0) exp_wr[g] = 1'b1;
    chk("wb_ready", 64'(wb_ready_o), exp_wr);
    for (int p = 0; p < NRP; p++) begin
      if (issue_ruse_i[p] && cnt_m[issue_raddr_i[p]] > 0 && can_fwd(p, g))
        chk("rdata_fwd", issue_rdata_o[p], wb_data_i[g]);
      else if (issue_ruse_i[p] && known[issue_raddr_i[p]])
        chk("rdata", issue_rdata_o[p], rf_m[issue_raddr_i[p]]);
    end
    ia = -1; da = -1; wa = -1; d = '0;
    if (issue_valid_i && rdy && issue_wuse_i) ia = int'(issue_waddr_i);
    if (g >= 0) begin
      wa = int'(wb_addr_i[g]);
      d  = wb_data_i[g];
    end
    @(posedge clk);
    #1;
    if (wa >= 0) begin
      rf_m[wa]  = d;
      known[wa] = 1'b1;
      if (cnt_m[wa] == 0) err_m = 1'b1;
      else                da = wa;
      ptr_m = (g + 1) % NWB;
    end
    if (ia >= 0 && ia != da) cnt_m[ia]++;
    if (da >= 0 && da != ia) cnt_m[da]--;
    exp_busy = '0;
    for (int r = 0; r < NR; r++) exp_busy[r] = (cnt_m[r] > 0);
    chk("busy", 64'(busy_o), exp_busy);
    chk("err", 64'(err_o), 64'(err_m));
    @(negedge clk);
  endtask

  // Reset with an issue attempt present, which must be ignored.
  task automatic do_reset(int ncyc);
    idle();
    rst_i = 1'b1;
    iss(1'b1, int'($urandom_range(0, 7)), 1'b0, 0);
    repeat (ncyc) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    idle();
    for (int r = 0; r < NR; r++) cnt_m[r] = 0;
    err_m = 1'b0;
    ptr_m = 0;
    #1;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_issue_ready", 64'(issue_ready_o), 64'd1);
    chk("rst_wb_ready", 64'(wb_ready_o), 64'd0);
  endtask

  initial begin
    for (int r = 0; r < NR; r++) begin
      cnt_m[r] = 0;
      known[r] = 1'b0;
      rf_m[r]  = '0;
    end
    err_m = 1'b0;
    ptr_m = 0;
    idle();
    rst_i = 1'b1;
    @(negedge clk);
    do_reset(2);

    // RAW on f3
    iss(1'b1, 3, 1'b0, 0); step();
    idle(); iss(1'b0, 0, 1'b1, 3);
    #1 chk("raw_stall", 64'(issue_ready_o), 64'd0);
    step();
    idle(); iss(1'b0, 0, 1'b1, 3); wbs(0, 3, 64'h3FF0000000000000); step();
    idle(); iss(1'b0, 0, 1'b1, 3);
    #1 chk("raw_rdata", issue_rdata_o[0], 64'h3FF0000000000000);
    chk("raw_ready", 64'(issue_ready_o), 64'd1);
    step();

    // Arbitration: both channels valid from reset
    do_reset(1);
    idle(); wbs(0, 1, 64'hAAAA); wbs(1, 2, 64'hBBBB);
    for (int k = 0; k < 4; k++) begin
      #1 chk("arb_grant", 64'(wb_ready_o), (k % 2 == 1) ? 64'd2 : 64'd1);
      step();
    end

    // Saturation on f5
    do_reset(1);
    for (int k = 0; k < 3; k++) begin
      idle(); iss(1'b1, 5, 1'b0, 0); step();
    end
    chk("sat_busy", 64'(busy_o[5]), 64'd1);
    idle(); iss(1'b1, 5, 1'b0, 0); wbs(1, 5, 64'h5555);
    #1 chk("sat_stall", 64'(issue_ready_o), 64'd0);
    step();
    idle(); iss(1'b1, 5, 1'b0, 0);
    #1 chk("sat_accept", 64'(issue_ready_o), 64'd1);
    step();

    // Simultaneous issue and write-back on f7
    do_reset(1);
    idle(); iss(1'b1, 7, 1'b0, 0); step();
    idle(); iss(1'b1, 7, 1'b0, 0); wbs(0, 7, 64'h7777); step();
    chk("simul_busy", 64'(busy_o[7]), 64'd1);
    idle(); wbs(0, 7, 64'h7778); step();
    chk("simul_drain", 64'(busy_o[7]), 64'd0);
    chk("simul_noerr", 64'(err_o), 64'd0);

    // Error on idle register, then reset mid-operation
    do_reset(1);
    idle(); wbs(0, 9, 64'h9999); step();
    chk("err_set", 64'(err_o), 64'd1);
    idle(); iss(1'b1, 4, 1'b0, 0); step();
    idle(); iss(1'b1, 4, 1'b0, 0); step();
    chk("busy_f4", 64'(busy_o[4]), 64'd1);
    do_reset(1);

    // Forwarding on f2
    idle(); iss(1'b1, 2, 1'b0, 0); step();
    idle(); iss(1'b0, 0, 1'b1, 2); wbs(0, 2, 64'h1234);
`ifdef SPATZ_FPR_FWD_EN
    #1 chk("fwd_ready", 64'(issue_ready_o), 64'd1);
    chk("fwd_rdata", issue_rdata_o[0], 64'h1234);
`else
    #1 chk("fwd_stall", 64'(issue_ready_o), 64'd0);
`endif
    step();
    idle(); iss(1'b0, 0, 1'b1, 2);
    #1 chk("fwd_next_rdata", issue_rdata_o[0], 64'h1234);
    chk("fwd_next_ready", 64'(issue_ready_o), 64'd1);
    step();

    // Random traffic on a small register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1);
      end else begin
        idle();
        issue_valid_i = 1'($urandom_range(0, 1));
        issue_ruse_i  = 3'($urandom_range(0, 7));
        for (int p = 0; p < NRP; p++) issue_raddr_i[p] = 5'($urandom_range(0, 7));
        issue_wuse_i  = 1'($urandom_range(0, 1));
        issue_waddr_i = 5'($urandom_range(0, 7));
        for (int c = 0; c < NWB; c++) begin
          if ($urandom_range(0, 9) < 4) begin
            int a;
            a = $urandom_range(0, 7);
            if ($urandom_range(0, 9) != 0)
              for (int t = 0; t < 8 && cnt_m[a] == 0; t++) a = $urandom_range(0, 7);
            wbs(c, a, {$urandom, $urandom});
          end
        end
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
